// File: rtl/gmii_rx_frame_if.sv
// rtl/gmii_rx_frame_if.sv - GMII receive byte stream in, framed payload stream and per-frame status out
interface gmii_rx_frame_if;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        frame_done;
    logic        frame_ok;
    logic        err_crc;
    logic        err_len;
    logic [10:0] frame_len;

    modport master (
        output gmii_rx_dv, gmii_rxd,
        input  out_valid, out_data, out_sof, out_eof,
        input  frame_done, frame_ok, err_crc, err_len, frame_len
    );

    modport slave (
        input  gmii_rx_dv, gmii_rxd,
        output out_valid, out_data, out_sof, out_eof,
        output frame_done, frame_ok, err_crc, err_len, frame_len
    );
endinterface

// File: rtl/gmii_rx_frame.sv
// rtl/gmii_rx_frame.sv - GMII rx framer: preamble strip, CRC-32 check, FCS drop, optional dest MAC filter
// Optional filter enabled by defining GMII_RX_MAC_FILTER_EN.
module gmii_rx_frame #(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
    parameter int          MIN_LEN   = 64,
    parameter int          MAX_LEN   = 1518
) (
    input  logic            gmii_rx_clk,
    input  logic            rst,
    gmii_rx_frame_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_t;

    localparam logic [10:0] L_MIN = 11'(MIN_LEN);
    localparam logic [10:0] L_MAX = 11'(MAX_LEN);

    state_t          r_state;
    logic            r_dv_d;
    logic [2:0]      r_pcnt;
    logic [31:0]     r_crc;
    logic [10:0]     r_cnt;
    logic [4:0][7:0] r_dl;
    logic            r_out_valid;
    logic [7:0]      r_out_data;
    logic            r_out_sof;
    logic            r_out_eof;
    logic            r_frame_done;
    logic            r_frame_ok;
    logic            r_err_crc;
    logic            r_err_len;
    logic [10:0]     r_frame_len;

    logic            w_err_crc;
    logic            w_err_len;
    logic            w_pass;
    logic            w_addr_ok;

    function automatic logic [31:0] f_crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            c = {1'b0, c[31:1]} ^ ((c[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
        end
        return c;
    endfunction

    assign w_err_crc = (r_crc != 32'hDEBB_20E3);
    assign w_err_len = (r_cnt < L_MIN) || (r_cnt > L_MAX);

`ifdef GMII_RX_MAC_FILTER_EN
    logic [47:0] w_dest;
    logic        w_addr_hit;
    logic        r_addr_ok;

    // byte 5 is still on the wire when byte 0 leaves the delay line
    assign w_dest     = {r_dl[4], r_dl[3], r_dl[2], r_dl[1], r_dl[0], bus.gmii_rxd};
    assign w_addr_hit = (w_dest == LOCAL_MAC) || (w_dest == 48'hFFFF_FFFF_FFFF);
    assign w_pass     = (r_cnt == 11'd5) ? w_addr_hit : r_addr_ok;
    assign w_addr_ok  = r_addr_ok;

    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            r_addr_ok <= 1'b0;
        end else if (r_state == S_PRE) begin
            r_addr_ok <= 1'b0;
        end else if (r_state == S_DATA && bus.gmii_rx_dv && r_cnt == 11'd5) begin
            r_addr_ok <= w_addr_hit;
        end
    end
`else
    assign w_pass    = 1'b1;
    assign w_addr_ok = 1'b1;
`endif

    always_ff @(posedge gmii_rx_clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_dv_d       <= 1'b1;
            r_pcnt       <= 3'd0;
            r_crc        <= 32'h0;
            r_cnt        <= 11'd0;
            r_dl         <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= 8'h0;
            r_out_sof    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_ok   <= 1'b0;
            r_err_crc    <= 1'b0;
            r_err_len    <= 1'b0;
            r_frame_len  <= 11'd0;
        end else begin
            r_dv_d       <= bus.gmii_rx_dv;
            r_out_valid  <= 1'b0;
            r_out_sof    <= 1'b0;
            r_out_eof    <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.gmii_rx_dv) begin
                        if (!r_dv_d && bus.gmii_rxd == 8'h55) begin
                            r_state <= S_PRE;
                            r_pcnt  <= 3'd1;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end
                end
                S_PRE: begin
                    if (!bus.gmii_rx_dv) begin
                        r_state <= S_IDLE;
                    end else if (bus.gmii_rxd == 8'h55) begin
                        if (r_pcnt == 3'd7) r_state <= S_DROP;
                        else                r_pcnt  <= r_pcnt + 3'd1;
                    end else if (bus.gmii_rxd == 8'hD5) begin
                        r_state <= S_DATA;
                        r_crc   <= 32'hFFFF_FFFF;
                        r_cnt   <= 11'd0;
                        r_dl    <= '0;
                    end else begin
                        r_state <= S_DROP;
                    end
                end
                S_DATA: begin
                    if (bus.gmii_rx_dv) begin
                        r_crc <= f_crc_byte(r_crc, bus.gmii_rxd);
                        r_dl  <= {r_dl[3:0], bus.gmii_rxd};
                        if (r_cnt != 11'h7FF) r_cnt <= r_cnt + 11'd1;
                        if (r_cnt >= 11'd5) begin
                            r_out_valid <= w_pass;
                            r_out_sof   <= w_pass && (r_cnt == 11'd5);
                            r_out_data  <= r_dl[4];
                        end
                    end else begin
                        // last four held bytes are the FCS and are dropped here
                        r_state      <= S_IDLE;
                        r_frame_done <= 1'b1;
                        r_err_crc    <= w_err_crc;
                        r_err_len    <= w_err_len;
                        r_frame_ok   <= !w_err_crc && !w_err_len && w_addr_ok;
                        r_frame_len  <= (r_cnt >= 11'd4) ? r_cnt - 11'd4 : 11'd0;
                        if (r_cnt >= 11'd5) begin
                            r_out_valid <= w_addr_ok;
                            r_out_sof   <= w_addr_ok && (r_cnt == 11'd5);
                            r_out_eof   <= w_addr_ok;
                            r_out_data  <= r_dl[4];
                        end
                    end
                end
                S_DROP: begin
                    if (!bus.gmii_rx_dv) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_sof    = r_out_sof;
    assign bus.out_eof    = r_out_eof;
    assign bus.frame_done = r_frame_done;
    assign bus.frame_ok   = r_frame_ok;
    assign bus.err_crc    = r_err_crc;
    assign bus.err_len    = r_err_len;
    assign bus.frame_len  = r_frame_len;
endmodule

// File: tb/tb_gmii_rx_frame.sv
// tb/tb_gmii_rx_frame.sv - directed self-checking bench for gmii_rx_frame
module tb_gmii_rx_frame;
    localparam logic [47:0] MAC   = 48'h00_0A_35_01_FE_C0;
    localparam logic [47:0] OTHER = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #4 clk = ~clk;

    gmii_rx_frame_if bus();

    gmii_rx_frame #(
        .LOCAL_MAC (MAC),
        .MIN_LEN   (64),
        .MAX_LEN   (1518)
    ) dut (
        .gmii_rx_clk (clk),
        .rst         (rst),
        .bus         (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0]  tx_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_a[$];
    logic [7:0]  rx_q[$];
    logic [13:0] st_q[$];
    int n_sof = 0;
    int n_eof = 0;
    int sof_idx = -1;
    int eof_idx = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (bus.out_sof) begin n_sof++; sof_idx = rx_q.size(); end
            if (bus.out_eof) begin n_eof++; eof_idx = rx_q.size(); end
            rx_q.push_back(bus.out_data);
        end
        if (bus.frame_done)
            st_q.push_back({bus.frame_ok, bus.err_crc, bus.err_len, bus.frame_len});
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++)
            c = (c >> 1) ^ ((c[0] ^ d[i]) ? 32'hEDB8_8320 : 32'h0);
        return c;
    endfunction

    task automatic build(input logic [47:0] dest, input int len, input int seed);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        exp_q.delete();
        tx_q.delete();
        for (int i = 0; i < len; i++) begin
            if (i < 6) b = dest[47 - 8*i -: 8];
            else       b = 8'(seed + i * 13);
            exp_q.push_back(b);
            tx_q.push_back(b);
            c = crc_upd(c, b);
        end
        c = ~c;
        tx_q.push_back(c[7:0]);
        tx_q.push_back(c[15:8]);
        tx_q.push_back(c[23:16]);
        tx_q.push_back(c[31:24]);
    endtask

    task automatic put(input logic dv, input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.gmii_rx_dv = dv;
        bus.gmii_rxd   = d;
    endtask

    task automatic send(input int npre);
        for (int i = 0; i < npre; i++) put(1'b1, 8'h55);
        put(1'b1, 8'hD5);
        foreach (tx_q[i]) put(1'b1, tx_q[i]);
        put(1'b0, 8'h00);
    endtask

    task automatic clear_mon();
        rx_q.delete();
        st_q.delete();
        n_sof = 0; n_eof = 0; sof_idx = -1; eof_idx = -1;
    endtask

    task automatic check_frame(input string tag, input bit deliver, input logic [13:0] exp_st);
        int mism;
        mism = 0;
        chk({tag, "_done"}, st_q.size(), 1);
        if (st_q.size() > 0) chk({tag, "_status"}, {18'h0, st_q[0]}, {18'h0, exp_st});
        chk({tag, "_nbytes"}, rx_q.size(), deliver ? exp_q.size() : 0);
        if (deliver) begin
            foreach (exp_q[i])
                if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) mism++;
            chk({tag, "_data"}, mism, 0);
            chk({tag, "_sof"}, {n_sof[15:0], sof_idx[15:0]}, {16'd1, 16'd0});
            chk({tag, "_eof"}, {n_eof[15:0], eof_idx[15:0]}, {16'd1, 16'(exp_q.size() - 1)});
        end
    endtask

    initial begin
        bus.gmii_rx_dv = 1'b0;
        bus.gmii_rxd   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_sof_eof", {bus.out_sof, bus.out_eof}, 0);
        chk("rst_status", {bus.frame_done, bus.frame_ok, bus.err_crc, bus.err_len, bus.frame_len}, 0);
        rst = 1'b0;
        repeat (3) put(1'b0, 8'h00);

        clear_mon(); build(MAC, 60, 3); send(7); repeat (3) put(1'b0, 8'h00);
        check_frame("good60", 1'b1, {1'b1, 1'b0, 1'b0, 11'd60});

        clear_mon(); build(MAC, 60, 3); tx_q[tx_q.size() - 1] ^= 8'h10; send(7); repeat (3) put(1'b0, 8'h00);
        check_frame("badfcs", 1'b1, {1'b0, 1'b1, 1'b0, 11'd60});

        clear_mon(); build(MAC, 40, 9); send(7); repeat (3) put(1'b0, 8'h00);
        check_frame("short40", 1'b1, {1'b0, 1'b0, 1'b1, 11'd40});

        clear_mon(); build(MAC, 1600, 21); send(7); repeat (3) put(1'b0, 8'h00);
        check_frame("long1600", 1'b1, {1'b0, 1'b0, 1'b1, 11'd1600});

        clear_mon(); build(MAC, 0, 0); send(7); repeat (3) put(1'b0, 8'h00);
        check_frame("n4", 1'b0, {1'b0, 1'b0, 1'b1, 11'd0});

`ifdef GMII_RX_MAC_FILTER_EN
        clear_mon(); build(OTHER, 60, 5); send(7); repeat (3) put(1'b0, 8'h00);
        check_frame("other_mac", 1'b0, {1'b0, 1'b0, 1'b0, 11'd60});
`else
        clear_mon(); build(OTHER, 60, 5); send(7); repeat (3) put(1'b0, 8'h00);
        check_frame("other_mac", 1'b1, {1'b1, 1'b0, 1'b0, 11'd60});
`endif

        clear_mon(); build(BCAST, 64, 7); send(7); repeat (3) put(1'b0, 8'h00);
        check_frame("bcast", 1'b1, {1'b1, 1'b0, 1'b0, 11'd64});

        clear_mon(); build(MAC, 60, 11);
        put(1'b1, 8'h55); put(1'b1, 8'h5D);
        send(5); repeat (3) put(1'b0, 8'h00);
        chk("badpre_done", st_q.size(), 0);
        chk("badpre_bytes", rx_q.size(), 0);

        clear_mon(); send(8); repeat (3) put(1'b0, 8'h00);
        chk("pre8_done", st_q.size(), 0);
        chk("pre8_bytes", rx_q.size(), 0);

        clear_mon(); build(MAC, 60, 31); exp_a = exp_q; send(7);
        build(MAC, 70, 47); send(1); repeat (3) put(1'b0, 8'h00);
        begin
            int mism;
            mism = 0;
            foreach (exp_q[i]) exp_a.push_back(exp_q[i]);
            chk("b2b_nbytes", rx_q.size(), 130);
            foreach (exp_a[i])
                if (i >= rx_q.size() || rx_q[i] !== exp_a[i]) mism++;
            chk("b2b_data", mism, 0);
            chk("b2b_sof_eof", {n_sof[15:0], n_eof[15:0]}, {16'd2, 16'd2});
            chk("b2b_done", st_q.size(), 2);
            if (st_q.size() == 2) begin
                chk("b2b_st0", {18'h0, st_q[0]}, {18'h0, 1'b1, 1'b0, 1'b0, 11'd60});
                chk("b2b_st1", {18'h0, st_q[1]}, {18'h0, 1'b1, 1'b0, 1'b0, 11'd70});
            end
        end

        clear_mon(); build(MAC, 60, 55);
        for (int i = 0; i < 7; i++) put(1'b1, 8'h55);
        put(1'b1, 8'hD5);
        for (int i = 0; i < 20; i++) put(1'b1, tx_q[i]);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out", {bus.out_valid, bus.out_sof, bus.out_eof, bus.frame_done}, 0);
        clear_mon();
        #2 rst = 1'b0;
        for (int i = 20; i < tx_q.size(); i++) put(1'b1, tx_q[i]);
        put(1'b0, 8'h00); repeat (3) put(1'b0, 8'h00);
        chk("midrst_done", st_q.size(), 0);
        chk("midrst_bytes", rx_q.size(), 0);

        clear_mon(); build(MAC, 60, 77); send(7); repeat (3) put(1'b0, 8'h00);
        check_frame("after_rst", 1'b1, {1'b1, 1'b0, 1'b0, 11'd60});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/gmii_rx_frame.md
# gmii_rx_frame

Receive-side Ethernet framer that consumes the GMII byte stream (`gmii_rx_dv`, `gmii_rxd`) produced by the RGMII receive stage, in the same `gmii_rx_clk` domain. It strips preamble/SFD, checks CRC-32, optionally filters on destination MAC, and drops the 4-byte FCS. It delivers a framed byte stream (valid/sof/eof) plus a per-frame status pulse to the MAC/UDP layers above.

## Interface
- `LOCAL_MAC`, default 48'h00_0A_35_01_FE_C0: station address, first byte on the wire = bits [47:40].
- `MIN_LEN`, default 64: minimum frame length in bytes, FCS included.
- `MAX_LEN`, default 1518: maximum frame length in bytes, FCS included.

Ports:
- `gmii_rx_clk` in 1: sole clock, 125 MHz.
- `rst` in 1: reset, asynchronous assert, active-high.
- `gmii_rx_dv` in 1: GMII data valid.
- `gmii_rxd` in 8: GMII receive byte.
- `out_valid` out 1: `out_data` holds a payload byte (dest MAC through last byte before FCS).
- `out_data` out 8: payload byte.
- `out_sof` out 1: first payload byte (dest MAC byte 0); qualified by `out_valid`.
- `out_eof` out 1: last payload byte; qualified by `out_valid`.
- `frame_done` out 1: one-cycle status pulse per frame that reached DATA.
- `frame_ok` out 1: valid with `frame_done`; CRC good, length good and address accepted.
- `err_crc` out 1: valid with `frame_done`; CRC residue mismatch.
- `err_len` out 1: valid with `frame_done`; N < MIN_LEN or N > MAX_LEN.
- `frame_len` out 11: valid with `frame_done`; N−4, saturating at 2047.

## Operation
- All outputs are registered. Every output resets to 0. FSM resets to IDLE. Internal `dv_d` resets to 1, so a frame in progress at reset release is ignored.
- FSM:
  - IDLE: on `dv` rising (`dv_d`=0) with `rxd`=0x55 → PREAMBLE. Any other `dv`=1 → DROP.
  - PREAMBLE: 0x55 increments `pcnt`. After 1..7 0x55, 0xD5 → DATA. 0x55 with `pcnt`=7, any other byte, → DROP. `dv`=0 → IDLE (no status).
  - DATA: each byte is fed into CRC, the byte counter N (saturating at 2047), and a 5-deep delay line. `dv`=0 → IDLE with end-of-frame handling.
  - DROP: wait for `dv`=0 → IDLE. No outputs.
- Delay line: on sampling byte k with k ≥ 5, byte k−5 is emitted with `out_valid`=1, and `out_sof`=1 when k=5.
- On `dv` falling in DATA with N ≥ 5:
  - Oldest held byte (N−5) is emitted with `out_eof`=1.
  - The 4 FCS bytes are discarded.
  - `frame_done` pulses in the same cycle.
- N < 5: nothing is emitted. `frame_done`=1, `err_len`=1, `frame_ok`=0.
- CRC-32: reflected polynomial 0xEDB88320, init 0xFFFFFFFF, byte processed LSB-first. Frame good ⇔ register = 0xDEBB20E3 after the last byte (FCS included).
- `frame_ok` = !`err_crc` & !`err_len` & `addr_ok`.
- Back-to-back frames with minimum 1-cycle `dv` gap: the IDLE decision uses the first byte after the gap. The delay line and CRC reinitialise on entry to DATA.

## Timing
- Latency: byte k sampled at edge t appears on `out_data` after edge t+5. eof/status appear after the edge sampling `dv`=0.
- `out_valid` is never asserted on consecutive frames without `out_eof` between them.
- Throughput: 1 byte/cycle, no backpressure.
- `rst` mid-frame: outputs drop to 0 immediately. No eof or status is issued for the aborted frame.

## Configuration
- `GMII_RX_MAC_FILTER_EN` defined:
  - `addr_ok` = dest MAC equals `LOCAL_MAC` or FF:FF:FF:FF:FF:FF. It is resolved combinationally at the edge sampling byte 5, which is the same edge that would emit byte 0.
  - On mismatch, `out_valid`/`out_sof`/`out_eof` stay 0 for the whole frame. `frame_done` still pulses with `frame_ok`=0.
- Undefined: `addr_ok`=1, all frames are delivered, and the comparator logic is absent.

## Test plan
- 7×0x55, 0xD5, 60-byte payload to `LOCAL_MAC`, correct FCS → 60 `out_valid` bytes matching input, `out_sof` on byte 0, `out_eof` on byte 59, `frame_done`=1, `frame_ok`=1, `frame_len`=60.
- Same frame with one FCS bit flipped → identical data stream, `err_crc`=1, `frame_ok`=0.
- 40-byte payload with good FCS (N=44) → `err_len`=1. Separately, 1600-byte payload → `err_len`=1 and `frame_len`=1600.
- With `GMII_RX_MAC_FILTER_EN`: dest 02:00:00:00:00:01 → no `out_valid`, `frame_done`=1, `frame_ok`=0. Broadcast dest → delivered, `frame_ok`=1.
- Bad preamble (0x55, 0x5D, …) → DROP, no outputs. Back-to-back good frames with 1-cycle gap → both delivered intact.
- `rst` pulsed mid-payload while `dv` stays high → outputs 0, rest of frame ignored, next frame delivered with `frame_ok`=1.
